// File: rtl/ecc_mod_mul.sv
// Iterative (a*b) mod M for the ECC accelerator.
// MSB-first interleaved shift-add reduction, one multiplier bit per cycle.
module ecc_mod_mul #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             modular_write_i,
    input  logic [WIDTH-1:0] modulo_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             finish_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        WAIT_LOW
    } state_e;

    state_e state_q;

    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] m_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] m_new;
    logic [WIDTH-1:0] a_red;
    logic [WIDTH:0]   t_dbl;
    logic [WIDTH-1:0] t_red;
    logic [WIDTH:0]   t_add;
    logic [WIDTH-1:0] t_out;

    // acc < m_s keeps every intermediate within WIDTH+1 bits
    always_comb begin
        m_new = modular_write_i ? modulo_i : mod_q;
        a_red = (a_i >= m_new) ? a_i - m_new : a_i;
        t_dbl = {acc, 1'b0};
        t_red = (t_dbl >= {1'b0, m_s}) ?
                WIDTH'(t_dbl - {1'b0, m_s}) : t_dbl[WIDTH-1:0];
        t_add = b_s[cnt] ? {1'b0, t_red} + {1'b0, a_s}
                         : {1'b0, t_red};
        t_out = (t_add >= {1'b0, m_s}) ?
                WIDTH'(t_add - {1'b0, m_s}) : t_add[WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            mod_q    <= '0;
            m_s      <= '0;
            a_s      <= '0;
            b_s      <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_o <= '0;
            finish_o <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            if (modular_write_i) begin
                mod_q <= modulo_i;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        m_s <= m_new;
                        a_s <= a_red;
                        b_s <= b_i;
                        acc <= '0;
                        cnt <= CW'(WIDTH - 1);
                        if (m_new <= WIDTH'(1)) begin
                            result_o <= '0;
                            finish_o <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            busy_o  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= t_out;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_o <= t_out;
                        finish_o <= 1'b1;
                        busy_o   <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    finish_o <= 1'b0;
                    state_q  <= start_i ? WAIT_LOW : IDLE;
                end
                WAIT_LOW: begin
                    if (!start_i) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
